// File: rtl/uart_sort_pkg.sv
// Shared constants and types for the framed UART <-> sorter link.
package uart_sort_pkg;

    localparam logic [7:0] SYNC_REQ = 8'hA5;
    localparam logic [7:0] SYNC_RSP = 8'h5A;

    typedef enum logic [7:0] {
        ST_OK       = 8'h00,
        ST_BAD_CSUM = 8'h01,
        ST_BAD_HDR  = 8'h02,
        ST_TIMEOUT  = 8'h03
    } status_t;

    // DRAIN holds a rejected header until the line goes quiet.
    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_CNT,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN,
        S_SORT_WAIT,
        S_TX_HDR,
        S_TX_STAT,
        S_TX_CNT,
        S_TX_DATA,
        S_TX_CSUM
    } link_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_PEND,
        SER_WAIT_HI,
        SER_WAIT_LO
    } ser_state_t;

    function automatic int unsigned BYTES_PER_WORD(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/uart_sort_link_if.sv
// Byte-stream and sorter bus bundle between uart_sort_link and its neighbours.
interface uart_sort_link_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    logic [7:0]                  rx_data;
    logic                        rx_valid;
    logic [7:0]                  tx_data;
    logic                        tx_start;
    logic                        tx_busy;
    logic [DEPTH-1:0][WIDTH-1:0] unsorted;
    logic                        sort_valid_in;
    logic [DEPTH-1:0][WIDTH-1:0] sorted;
    logic                        sort_valid_out;

    // master = the link controller
    modport master (
        input  rx_data, rx_valid, tx_busy, sorted, sort_valid_out,
        output tx_data, tx_start, unsorted, sort_valid_in
    );

    // slave = uart pair plus sorter
    modport slave (
        output rx_data, rx_valid, tx_busy, sorted, sort_valid_out,
        input  tx_data, tx_start, unsorted, sort_valid_in
    );
endinterface

// File: rtl/sort_link_tx_ser.sv
// Byte serialiser: owns the tx_start/tx_busy handshake with uart_tx.
// A load fires immediately when the line is free, otherwise it is parked.
// done pulses in the cycle uart_tx drops busy, and a load in that same
// cycle is launched straight away, so bytes go out back to back.
module sort_link_tx_ser
    import uart_sort_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [7:0] ld_byte,
    output logic       done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy
);
    ser_state_t state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;
    logic       can_fire;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SER_IDLE;
            byte_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    // handshake sequencing: fire, wait busy high, wait busy low
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        done       = 1'b0;
        can_fire   = !tx_busy && !tx_start_q;
        case (state_q)
            SER_PEND: begin
                if (can_fire) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = byte_q;
                    state_d    = SER_WAIT_HI;
                end
            end
            SER_WAIT_HI: if (tx_busy) state_d = SER_WAIT_LO;
            SER_WAIT_LO: begin
                if (!tx_busy) begin
                    done    = 1'b1;
                    state_d = SER_IDLE;
                end
            end
            default: ;
        endcase
        if (ld) begin
            if (can_fire) begin
                tx_start_d = 1'b1;
                tx_data_d  = ld_byte;
                state_d    = SER_WAIT_HI;
            end else begin
                byte_d  = ld_byte;
                state_d = SER_PEND;
            end
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;

endmodule

// File: rtl/uart_sort_link.sv
// Framed request/response controller between the UART byte pair and sort_top.
// Receives a checksummed request, pads unused sorter slots with all-ones,
// launches the sort and streams back the real words in the requested order.
module uart_sort_link
    import uart_sort_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    uart_sort_link_if.master  lnk,
    output logic              busy,
    output logic [7:0]        err_count
);
    localparam int BPW = int'(BYTES_PER_WORD(WIDTH));
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int IW  = $clog2(DEPTH);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    link_state_t                 state_q, state_d;
    status_t                     status_q, status_d;
    logic [7:0]                  cmd_q, cmd_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic [7:0]                  idx_q, idx_d;
    logic [BW-1:0]               bcnt_q, bcnt_d;
    logic [TW-1:0]               tmr_q, tmr_d;
    logic [7:0]                  csum_q, csum_d;
    logic [DEPTH-1:0][WIDTH-1:0] unsorted_q, unsorted_d;
    logic [DEPTH-1:0][WIDTH-1:0] res_q, res_d;
    logic                        sort_vld_q, sort_vld_d;
    logic [7:0]                  err_q, err_d;
    logic [7:0]                  oidx_q, oidx_d;
    logic [BW-1:0]               obyte_q, obyte_d;

    logic          ser_ld, ser_done;
    logic [7:0]    ser_byte;
    logic          err_go, tmr_hit, timed;
    status_t       err_st;
    logic [7:0]    rc, nb;
    logic [WIDTH+7:0] word_sh;

    // Byte b (0 = MSB) of the o-th transmitted word; descending walks backwards.
    function automatic logic [7:0] resp_byte(input logic [7:0] o, input logic [BW-1:0] b);
        logic [IW-1:0] w;
        w = cmd_q[0] ? IW'(cnt_q - 8'd1 - o) : IW'(o);
        return res_q[w][(BPW - 1 - int'(b)) * 8 +: 8];
    endfunction

    sort_link_tx_ser u_ser (
        .clk      (clk),
        .rst      (rst),
        .ld       (ser_ld),
        .ld_byte  (ser_byte),
        .done     (ser_done),
        .tx_data  (lnk.tx_data),
        .tx_start (lnk.tx_start),
        .tx_busy  (lnk.tx_busy)
    );

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            status_q   <= ST_OK;
            cmd_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            bcnt_q     <= '0;
            tmr_q      <= '0;
            csum_q     <= '0;
            unsorted_q <= '0;
            res_q      <= '0;
            sort_vld_q <= 1'b0;
            err_q      <= '0;
            oidx_q     <= '0;
            obyte_q    <= '0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            bcnt_q     <= bcnt_d;
            tmr_q      <= tmr_d;
            csum_q     <= csum_d;
            unsorted_q <= unsorted_d;
            res_q      <= res_d;
            sort_vld_q <= sort_vld_d;
            err_q      <= err_d;
            oidx_q     <= oidx_d;
            obyte_q    <= obyte_d;
        end
    end

    // frame parsing, sort launch and response sequencing
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        csum_d     = csum_q;
        unsorted_d = unsorted_q;
        res_d      = res_q;
        sort_vld_d = 1'b0;
        err_d      = err_q;
        oidx_d     = oidx_q;
        obyte_d    = obyte_q;
        ser_ld     = 1'b0;
        ser_byte   = '0;
        err_go     = 1'b0;
        err_st     = ST_OK;
        rc         = '0;
        nb         = '0;
        word_sh    = '0;

        // silence timer runs only while a request is being received
        timed   = state_q inside {S_CMD, S_CNT, S_PAYLOAD, S_CSUM, S_DRAIN};
        tmr_hit = (tmr_q == TW'(TIMEOUT_CYC - 1)) && !lnk.rx_valid;
        tmr_d   = (timed && !lnk.rx_valid) ? tmr_q + TW'(1) : '0;

        case (state_q)
            S_IDLE: begin
                if (lnk.rx_valid && lnk.rx_data == SYNC_REQ) begin
                    state_d = S_CMD;
                    csum_d  = '0;
                end
            end
            S_CMD: begin
                if (lnk.rx_valid) begin
                    cmd_d   = lnk.rx_data;
                    csum_d  = csum_q ^ lnk.rx_data;
                    state_d = S_CNT;
                end else if (tmr_hit) begin
                    err_go = 1'b1;
                    err_st = ST_TIMEOUT;
                end
            end
            S_CNT: begin
                if (lnk.rx_valid) begin
                    cnt_d  = lnk.rx_data;
                    csum_d = csum_q ^ lnk.rx_data;
                    if (lnk.rx_data == 8'd0 || lnk.rx_data > 8'(DEPTH) || cmd_q[7:1] != 7'd0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d    = S_PAYLOAD;
                        idx_d      = '0;
                        bcnt_d     = '0;
                        unsorted_d = '1;   // pads: slots never written stay all-ones
                    end
                end else if (tmr_hit) begin
                    err_go = 1'b1;
                    err_st = ST_TIMEOUT;
                end
            end
            S_PAYLOAD: begin
                if (lnk.rx_valid) begin
                    csum_d  = csum_q ^ lnk.rx_data;
                    word_sh = {unsorted_q[idx_q[IW-1:0]], lnk.rx_data};
                    unsorted_d[idx_q[IW-1:0]] = word_sh[WIDTH-1:0];
                    if (bcnt_q == BW'(BPW - 1)) begin
                        bcnt_d = '0;
                        idx_d  = idx_q + 8'd1;
                        if (idx_q == cnt_q - 8'd1) state_d = S_CSUM;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end else if (tmr_hit) begin
                    err_go = 1'b1;
                    err_st = ST_TIMEOUT;
                end
            end
            S_CSUM: begin
                if (lnk.rx_valid) begin
                    if (lnk.rx_data == csum_q) begin
                        sort_vld_d = 1'b1;
                        state_d    = S_SORT_WAIT;
                    end else begin
                        err_go = 1'b1;
                        err_st = ST_BAD_CSUM;
                    end
                end else if (tmr_hit) begin
                    err_go = 1'b1;
                    err_st = ST_TIMEOUT;
                end
            end
            S_DRAIN: begin
                if (tmr_hit) begin
                    err_go = 1'b1;
                    err_st = ST_BAD_HDR;
                end
            end
            S_SORT_WAIT: begin
                if (lnk.sort_valid_out) begin
                    res_d    = lnk.sorted;
                    status_d = ST_OK;
                    state_d  = S_TX_HDR;
                    ser_ld   = 1'b1;
                    ser_byte = SYNC_RSP;
                end
            end
            S_TX_HDR: begin
                if (ser_done) begin
                    ser_ld   = 1'b1;
                    ser_byte = status_q;
                    state_d  = S_TX_STAT;
                end
            end
            S_TX_STAT: begin
                if (ser_done) begin
                    rc       = (status_q == ST_OK) ? cnt_q : 8'd0;
                    ser_ld   = 1'b1;
                    ser_byte = rc;
                    csum_d   = status_q ^ rc;
                    state_d  = S_TX_CNT;
                end
            end
            S_TX_CNT: begin
                if (ser_done) begin
                    if (status_q != ST_OK) begin
                        ser_ld   = 1'b1;
                        ser_byte = csum_q;
                        state_d  = S_TX_CSUM;
                    end else begin
                        oidx_d   = '0;
                        obyte_d  = '0;
                        nb       = resp_byte(8'd0, '0);
                        ser_ld   = 1'b1;
                        ser_byte = nb;
                        csum_d   = csum_q ^ nb;
                        state_d  = S_TX_DATA;
                    end
                end
            end
            S_TX_DATA: begin
                if (ser_done) begin
                    if (obyte_q == BW'(BPW - 1) && oidx_q == cnt_q - 8'd1) begin
                        ser_ld   = 1'b1;
                        ser_byte = csum_q;
                        state_d  = S_TX_CSUM;
                    end else begin
                        if (obyte_q == BW'(BPW - 1)) begin
                            oidx_d  = oidx_q + 8'd1;
                            obyte_d = '0;
                        end else begin
                            obyte_d = obyte_q + BW'(1);
                        end
                        nb       = resp_byte(oidx_d, obyte_d);
                        ser_ld   = 1'b1;
                        ser_byte = nb;
                        csum_d   = csum_q ^ nb;
                    end
                end
            end
            S_TX_CSUM: begin
                if (ser_done) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    oidx_d  = '0;
                    obyte_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // error responses start with the sync byte in the decision cycle
        if (err_go) begin
            state_d  = S_TX_HDR;
            status_d = err_st;
            ser_ld   = 1'b1;
            ser_byte = SYNC_RSP;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
    end

    assign lnk.unsorted      = unsorted_q;
    assign lnk.sort_valid_in = sort_vld_q;
    assign busy              = (state_q != S_IDLE);
    assign err_count         = err_q;

endmodule

// File: tb/tb_uart_sort_link.sv
// Directed bench for uart_sort_link with a uart_tx/sort_top model and a
// frame-level response model.
module tb_uart_sort_link;
    localparam int W = 32;
    localparam int D = 8;
    localparam int T = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [7:0] err_count;

    uart_sort_link_if #(.WIDTH(W), .DEPTH(D)) lnk ();

    uart_sort_link #(.WIDTH(W), .DEPTH(D), .TIMEOUT_CYC(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .lnk       (lnk),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int sv_cnt = 0, exp_sv = 0, exp_err = 0;
    int busy_cnt = 0;
    int sdly = 0;
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    logic [7:0] cmp_e;
    logic [D-1:0][W-1:0] exp_uns;
    logic [W-1:0] req_w[D];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    // uart_tx model: busy for 4 cycles after each start
    assign lnk.tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (lnk.tx_start) busy_cnt <= 4;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    function automatic logic [D-1:0][W-1:0] sort_asc(input logic [D-1:0][W-1:0] a);
        logic [W-1:0] t;
        for (int i = 0; i < D - 1; i++)
            for (int j = 0; j < D - 1 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a;
    endfunction

    // sort_top model: result strobe 3 cycles after launch
    always @(posedge clk) begin
        if (rst) begin
            lnk.sorted         <= '0;
            lnk.sort_valid_out <= 1'b0;
            sdly               <= 0;
        end else begin
            lnk.sort_valid_out <= 1'b0;
            if (lnk.sort_valid_in) begin
                lnk.sorted <= sort_asc(lnk.unsorted);
                sdly       <= 3;
            end else if (sdly != 0) begin
                sdly <= sdly - 1;
                if (sdly == 1) lnk.sort_valid_out <= 1'b1;
            end
        end
    end

    // compare process: every transmitted byte and every sort launch
    always @(negedge clk) begin
        if (!rst) begin
            if (lnk.tx_start) begin
                log_q.push_back(lnk.tx_data);
                chk("start_while_busy", 64'(lnk.tx_busy), 64'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tx: got %02h want nothing", lnk.tx_data);
                end else begin
                    cmp_e = exp_q.pop_front();
                    chk("tx_byte", 64'(lnk.tx_data), 64'(cmp_e));
                end
            end
            if (lnk.sort_valid_in) begin
                sv_cnt++;
                total++;
                if (lnk.unsorted !== exp_uns) begin
                    bad++;
                    $display("FAIL unsorted: got %h want %h", lnk.unsorted, exp_uns);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        lnk.rx_data  = b;
        lnk.rx_valid = 1'b1;
        @(negedge clk);
        lnk.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input int cnt, input bit corrupt);
        logic [7:0] cs;
        logic [7:0] b;
        cs = cmd ^ 8'(cnt);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(8'(cnt));
        for (int i = 0; i < cnt; i++)
            for (int k = W / 8 - 1; k >= 0; k--) begin
                b  = req_w[i][8*k +: 8];
                cs = cs ^ b;
                send_byte(b);
            end
        if (corrupt) cs = cs ^ 8'h01;
        send_byte(cs);
    endtask

    // response model: real words sorted, reversed for descending, pads never sent
    task automatic expect_ok(input logic [7:0] cmd, input int cnt);
        logic [W-1:0] s[D];
        logic [W-1:0] t, wv;
        logic [7:0] cs;
        for (int i = 0; i < cnt; i++) s[i] = req_w[i];
        for (int i = 1; i < cnt; i++)
            for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
                t = s[j]; s[j] = s[j-1]; s[j-1] = t;
            end
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(cnt));
        cs = 8'(cnt);
        for (int k = 0; k < cnt; k++) begin
            wv = cmd[0] ? s[cnt-1-k] : s[k];
            for (int b = W / 8 - 1; b >= 0; b--) begin
                exp_q.push_back(wv[8*b +: 8]);
                cs = cs ^ wv[8*b +: 8];
            end
        end
        exp_q.push_back(cs);
        for (int i = 0; i < D; i++) exp_uns[i] = (i < cnt) ? req_w[i] : '1;
        exp_sv++;
    endtask

    task automatic expect_err(input logic [7:0] st);
        exp_q.push_back(8'h5A);
        exp_q.push_back(st);
        exp_q.push_back(8'h00);
        exp_q.push_back(st);
        if (exp_err < 255) exp_err++;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 4000) begin
            bad++;
            $display("FAIL %s_timeout: got %0d bytes pending want 0", name, exp_q.size());
        end
    endtask

    task automatic post_chk(input string name);
        chk({name, "_err_count"}, 64'(err_count), 64'(exp_err));
        chk({name, "_sort_pulses"}, 64'(sv_cnt), 64'(exp_sv));
    endtask

    initial begin
        int n;
        lnk.rx_data  = '0;
        lnk.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_data", 64'(lnk.tx_data), 64'd0);
        chk("rst_tx_start", 64'(lnk.tx_start), 64'd0);
        chk("rst_sort_valid_in", 64'(lnk.sort_valid_in), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        total++;
        if (lnk.unsorted !== '0) begin
            bad++;
            $display("FAIL rst_unsorted: got %h want 0", lnk.unsorted);
        end

        // ascending, full frame
        for (int i = 0; i < D; i++) req_w[i] = W'(D - i);
        log_q.delete();
        expect_ok(8'h00, 8);
        send_frame(8'h00, 8, 1'b0);
        wait_done("asc8");
        chk("asc8_len", 64'(log_q.size()), 64'd36);
        chk("asc8_rcount", 64'(log_q[2]), 64'h08);
        chk("asc8_csum", 64'(log_q[35]), 64'h00);
        post_chk("asc8");

        // descending, 3 words
        req_w[0] = 32'd10; req_w[1] = 32'd30; req_w[2] = 32'd20;
        log_q.delete();
        expect_ok(8'h01, 3);
        send_frame(8'h01, 3, 1'b0);
        wait_done("desc3");
        chk("desc3_len", 64'(log_q.size()), 64'd16);
        chk("desc3_first_lsb", 64'(log_q[6]), 64'h1E);
        chk("desc3_last_lsb", 64'(log_q[14]), 64'h0A);
        chk("desc3_csum", 64'(log_q[15]), 64'h03);
        post_chk("desc3");

        // corrupted checksum
        log_q.delete();
        expect_err(8'h01);
        send_frame(8'h00, 3, 1'b1);
        wait_done("badcs");
        chk("badcs_status", 64'(log_q[1]), 64'h01);
        chk("badcs_csum", 64'(log_q[3]), 64'h01);
        chk("badcs_err_lit", 64'(err_count), 64'd1);
        post_chk("badcs");

        // COUNT above DEPTH, COUNT zero, reserved CMD bit set
        log_q.delete();
        expect_err(8'h02);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h09);
        wait_done("cnt9");
        chk("cnt9_csum", 64'(log_q[3]), 64'h02);
        expect_err(8'h02);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        wait_done("cnt0");
        expect_err(8'h02);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
        wait_done("badcmd");
        chk("hdr_err_lit", 64'(err_count), 64'd4);
        post_chk("hdr");

        // stall mid-payload, then garbage, then a good frame
        log_q.delete();
        expect_err(8'h03);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
        wait_done("stall");
        chk("stall_status", 64'(log_q[1]), 64'h03);
        send_byte(8'h00);
        send_byte(8'hFF);
        req_w[0] = 32'hDEAD0001; req_w[1] = 32'h00000002;
        expect_ok(8'h00, 2);
        send_frame(8'h00, 2, 1'b0);
        wait_done("after_garbage");
        post_chk("stall");

        // reset during payload transmission while the line is idle
        for (int i = 0; i < D; i++) req_w[i] = W'(D - i);
        log_q.delete();
        expect_ok(8'h00, 8);
        send_frame(8'h00, 8, 1'b0);
        n = 0;
        while (!(log_q.size() >= 5 && !lnk.tx_busy && !lnk.tx_start) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached", 64'(n < 2000), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_tx_start", 64'(lnk.tx_start), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("rst_mid_tx_start2", 64'(lnk.tx_start), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_err = 0;
        chk("rst_mid_err_count", 64'(err_count), 64'd0);

        // normal frame afterwards; a frame sent during the response is dropped
        log_q.delete();
        req_w[0] = 32'h00000005;
        expect_ok(8'h00, 1);
        send_frame(8'h00, 1, 1'b0);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h07); send_byte(8'h06);
        wait_done("post_rst");
        repeat (150) @(negedge clk);
        chk("post_rst_len", 64'(log_q.size()), 64'd8);
        chk("post_rst_idle", 64'(busy), 64'd0);
        post_chk("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
